mmio_bus_ctrl: RTL and testbench
================================

// Module: mmio_bus_ctrl
// PURPOSE
//  Parametrised memory-mapped I/O controller between the CPU (mem_cmd/mem_addr/write_data/read_data) and RAM.
//  Generalises single-LED/single-switch decode: NUM_OUT writable output regs, NUM_IN input ports, sticky change-events.
//  All read sources registered -> uniform 1-cycle read latency matching RAM; read_data is driven, never tri-stated.
// PARAMETERS
//  DATA_W   16  data bus width
//  ADDR_W   9   mem_addr width; MSB=0 selects RAM, MSB=1 selects I/O
//  NUM_OUT  2   number of output registers (1..2**(ADDR_W-3))
//  NUM_IN   2   number of input ports (1..2**(ADDR_W-3))
// PORTS
//  clk         in   1                  rising-edge clock
//  reset       in   1                  synchronous, active-high
//  mem_cmd     in   2                  00 MNONE, 01 MREAD, 10 MWRITE, 11 treated as MNONE
//  mem_addr    in   ADDR_W             CPU byte-free word address
//  write_data  in   DATA_W             CPU write data
//  read_data   out  DATA_W             read result, valid the cycle after MREAD
//  rd_valid    out  1                  high the cycle after an accepted MREAD
//  ram_we      out  1                  RAM write strobe (combinational)
//  ram_dout    in   DATA_W             RAM registered read data (1-cycle latency)
//  out_port    out  NUM_OUT*DATA_W     output regs; reg i at [i*DATA_W +: DATA_W]
//  in_port     in   NUM_IN*DATA_W      inputs; port i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  Decode: ofs = mem_addr[ADDR_W-2:0]; Q = 2**(ADDR_W-3) (0x40 at default).
//   MSB=0 -> RAM. MSB=1: ofs in [0,NUM_OUT) -> OUT[ofs]; [Q,Q+NUM_IN) -> IN[ofs-Q];
//   [2Q,2Q+NUM_IN) -> EVT[ofs-2Q]; anything else unmapped. Defaults: OUT 0x100.., IN 0x140.., EVT 0x180..
//  ram_we = (mem_cmd==MWRITE) & MSB==0; combinational, no register.
//  Write: MWRITE to OUT[i] loads write_data at the edge; out_port visible next cycle.
//   Writes to IN/EVT/unmapped ignored.
//  Input sampling: in_smp[i] <= in_port[i] every cycle.
//   evt[i] |= (in_port[i] ^ in_smp[i]) per bit, every cycle (sticky change detect).
//  Read (MREAD at edge k): capture source select + data; at cycle k+1: rd_valid=1 and
//   RAM -> ram_dout (pass-through of selected source); OUT[i] -> out reg value;
//   IN[i] -> in_port[i] as sampled at edge k; EVT[i] -> evt[i] value before clear; unmapped -> 0.
//  Read-to-clear: EVT read at edge k clears evt[i] except bits that change in that same cycle
//   (new change wins: evt <= change_mask).
//  No MREAD at edge k -> cycle k+1: rd_valid=0, read_data=0.
//  Back-to-back MREADs: one result per cycle, in order, no stall.
//  Reset (sync, wins over everything): out_port=0, evt=0, rd_valid=0, read_data=0;
//   in_smp <= in_port during reset so no spurious event on first cycle after reset.
//   ram_we is combinational and must be ignored by RAM while reset is high.
//   Reset mid-read: pending result discarded (rd_valid=0 next cycle).
// TESTING
//  MWRITE 0x100, data 0x00A5 -> ram_we=0; out_port[15:0]=0x00A5 next cycle; out reg 1 unchanged.
//  in_port[15:0]=0x0055; MREAD 0x140 -> next cycle rd_valid=1, read_data=0x0055.
//  MWRITE 0x010 -> ram_we=1 same cycle; MREAD 0x010 with ram_dout=0x1234 -> read_data=0x1234.
//  Toggle in_port[3] 0->1; MREAD 0x180 -> 0x0008; MREAD 0x180 again -> 0x0000.
//  Toggle in_port[0] in same cycle as EVT-read -> returns prior bits; following read returns 0x0001.
//  Assert reset with out_port=0xBEEF and evt!=0 -> out_port=0, evt=0; MREAD 0x1C0 -> read_data=0.

Source files
------------

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped I/O controller between the CPU and RAM.
// Output registers, sampled input ports and sticky change events share one read path.
module mmio_bus_ctrl #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 9,
   parameter int NUM_OUT = 2,
   parameter int NUM_IN  = 2
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [1:0]                i_mem_cmd,
   input  logic [ADDR_W-1:0]         i_mem_addr,
   input  logic [DATA_W-1:0]         i_write_data,
   output logic [DATA_W-1:0]         o_read_data,
   output logic                      o_rd_valid,
   output logic                      o_ram_we,
   input  logic [DATA_W-1:0]         i_ram_dout,
   output logic [NUM_OUT*DATA_W-1:0] o_out_port,
   input  logic [NUM_IN*DATA_W-1:0]  i_in_port
);

   localparam int OW = ADDR_W - 1;
   localparam int Q  = 2 ** (ADDR_W - 3);

   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   logic [OW-1:0]     w_ofs;
   logic              w_io;
   logic              w_rd;
   logic              w_wr;

   logic [DATA_W-1:0] r_out [NUM_OUT];
   logic [DATA_W-1:0] r_smp [NUM_IN];
   logic [DATA_W-1:0] r_evt [NUM_IN];
   logic [DATA_W-1:0] w_in  [NUM_IN];
   logic [DATA_W-1:0] w_chg [NUM_IN];

   logic [NUM_OUT-1:0] w_out_hit;
   logic [NUM_IN-1:0]  w_in_hit;
   logic [NUM_IN-1:0]  w_evt_hit;
   logic [DATA_W-1:0]  w_sel_data;

   logic              r_valid;
   logic              r_src_ram;
   logic [DATA_W-1:0] r_rdata;

   assign w_ofs = i_mem_addr[OW-1:0];
   assign w_io  = i_mem_addr[ADDR_W-1];
   assign w_rd  = (i_mem_cmd == MREAD);
   assign w_wr  = (i_mem_cmd == MWRITE);

   assign o_ram_we = w_wr & ~w_io;

   for (genvar g = 0; g < NUM_IN; g++) begin : g_in
      assign w_in[g]  = i_in_port[g*DATA_W +: DATA_W];
      assign w_chg[g] = w_in[g] ^ r_smp[g];
   end

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      assign o_out_port[g*DATA_W +: DATA_W] = r_out[g];
   end

   // Address decode of the I/O window and selection of the read source data.
   always_comb begin
      w_out_hit  = '0;
      w_in_hit   = '0;
      w_evt_hit  = '0;
      w_sel_data = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (w_io && (w_ofs == OW'(i))) begin
            w_out_hit[i] = 1'b1;
            w_sel_data   = r_out[i];
         end
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (w_io && (w_ofs == OW'(Q + i))) begin
            w_in_hit[i] = 1'b1;
            w_sel_data  = w_in[i];
         end
         if (w_io && (w_ofs == OW'(2 * Q + i))) begin
            w_evt_hit[i] = 1'b1;
            w_sel_data   = r_evt[i];
         end
      end
   end

   // Read pipeline stage: capture the selected source for the next cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_valid   <= 1'b0;
         r_src_ram <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_valid   <= w_rd;
         r_src_ram <= w_rd & ~w_io;
         r_rdata   <= w_rd ? w_sel_data : '0;
      end
   end

   assign o_rd_valid  = r_valid;
   assign o_read_data = r_src_ram ? i_ram_dout : r_rdata;

   // Output registers loaded by CPU writes into the OUT window.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_OUT; i++) r_out[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_OUT; i++) begin
            if (w_wr && w_out_hit[i]) r_out[i] <= i_write_data;
         end
      end
   end

   // Input sampling and sticky change events; a fresh change survives a clearing read.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_IN; i++) begin
            r_smp[i] <= w_in[i];
            r_evt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_IN; i++) begin
            r_smp[i] <= w_in[i];
            if (w_rd && w_evt_hit[i]) r_evt[i] <= w_chg[i];
            else                      r_evt[i] <= r_evt[i] | w_chg[i];
         end
      end
   end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Bench for mmio_bus_ctrl: vector table plus event and reset sequences.
// Read results are predicted into a queue and compared one cycle later.
module tb_mmio_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] write_data;
   logic [15:0] read_data;
   logic        rd_valid;
   logic        ram_we;
   logic [15:0] ram_dout;
   logic [31:0] out_port;
   logic [31:0] in_port;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        v;
      logic [15:0] d;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      logic [1:0]  cmd;
      logic [8:0]  addr;
      logic [15:0] wd;
      logic [31:0] inp;
      logic        we;
      logic        rv;
      logic [15:0] rd;
      logic [31:0] out;
   } vec_t;

   vec_t tbl[15];

   mmio_bus_ctrl dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_mem_cmd    (mem_cmd),
      .i_mem_addr   (mem_addr),
      .i_write_data (write_data),
      .o_read_data  (read_data),
      .o_rd_valid   (rd_valid),
      .o_ram_we     (ram_we),
      .i_ram_dout   (ram_dout),
      .o_out_port   (out_port),
      .i_in_port    (in_port)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] c, input logic [8:0] a,
                        input logic [15:0] w);
      mem_cmd    = c;
      mem_addr   = a;
      write_data = w;
   endtask

   // Inputs are already driven; check ram_we, predict, clock, compare.
   task automatic tick(input logic we, input logic rv,
                       input logic [15:0] rd, input logic [31:0] out,
                       input string nm);
      exp_t e;
      #1;
      chk({nm, "_we"}, {31'd0, ram_we}, {31'd0, we});
      sb.push_back('{rv, rd});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_sb: got empty queue expected entry", nm);
      end else begin
         e = sb.pop_front();
         chk({nm, "_rv"}, {31'd0, rd_valid}, {31'd0, e.v});
         chk({nm, "_rd"}, {16'd0, read_data}, {16'd0, e.d});
      end
      chk({nm, "_out"}, out_port, out);
   endtask

   localparam logic [1:0] NONE = 2'b00;
   localparam logic [1:0] RD   = 2'b01;
   localparam logic [1:0] WR   = 2'b10;
   localparam logic [1:0] BAD  = 2'b11;

   initial begin
      tbl[0]  = '{WR,   9'h100, 16'h00A5, 32'h0000_0055, 1'b0, 1'b0, 16'h0000, 32'h0000_00A5};
      tbl[1]  = '{WR,   9'h101, 16'hBEEF, 32'h0000_0055, 1'b0, 1'b0, 16'h0000, 32'hBEEF_00A5};
      tbl[2]  = '{RD,   9'h140, 16'h0000, 32'h0000_0055, 1'b0, 1'b1, 16'h0055, 32'hBEEF_00A5};
      tbl[3]  = '{RD,   9'h141, 16'h0000, 32'h7777_0055, 1'b0, 1'b1, 16'h7777, 32'hBEEF_00A5};
      tbl[4]  = '{WR,   9'h010, 16'h9999, 32'h7777_0055, 1'b1, 1'b0, 16'h0000, 32'hBEEF_00A5};
      tbl[5]  = '{RD,   9'h010, 16'h0000, 32'h7777_0055, 1'b0, 1'b1, 16'h1234, 32'hBEEF_00A5};
      tbl[6]  = '{RD,   9'h100, 16'h0000, 32'h7777_0055, 1'b0, 1'b1, 16'h00A5, 32'hBEEF_00A5};
      tbl[7]  = '{RD,   9'h101, 16'h0000, 32'h7777_0055, 1'b0, 1'b1, 16'hBEEF, 32'hBEEF_00A5};
      tbl[8]  = '{RD,   9'h102, 16'h0000, 32'h7777_0055, 1'b0, 1'b1, 16'h0000, 32'hBEEF_00A5};
      tbl[9]  = '{WR,   9'h142, 16'hFFFF, 32'h7777_0055, 1'b0, 1'b0, 16'h0000, 32'hBEEF_00A5};
      tbl[10] = '{WR,   9'h102, 16'hFFFF, 32'h7777_0055, 1'b0, 1'b0, 16'h0000, 32'hBEEF_00A5};
      tbl[11] = '{BAD,  9'h100, 16'h1111, 32'h7777_0055, 1'b0, 1'b0, 16'h0000, 32'hBEEF_00A5};
      tbl[12] = '{NONE, 9'h140, 16'h0000, 32'h7777_0055, 1'b0, 1'b0, 16'h0000, 32'hBEEF_00A5};
      tbl[13] = '{RD,   9'h1C0, 16'h0000, 32'h7777_0055, 1'b0, 1'b1, 16'h0000, 32'hBEEF_00A5};
      tbl[14] = '{WR,   9'h180, 16'h2222, 32'h7777_0055, 1'b0, 1'b0, 16'h0000, 32'hBEEF_00A5};

      reset    = 1'b1;
      ram_dout = 16'h1234;
      in_port  = 32'h0;
      drive(NONE, 9'h0, 16'h0);
      @(posedge clk);
      #1;
      tick(1'b0, 1'b0, 16'h0, 32'h0, "rst");
      reset = 1'b0;

      for (int i = 0; i < $size(tbl); i++) begin
         drive(tbl[i].cmd, tbl[i].addr, tbl[i].wd);
         in_port = tbl[i].inp;
         tick(tbl[i].we, tbl[i].rv, tbl[i].rd, tbl[i].out,
              $sformatf("vec%0d", i));
      end

      // RAM data is passed through in the result cycle.
      ram_dout = 16'hCAFE;
      drive(RD, 9'h020, 16'h0);
      tick(1'b0, 1'b1, 16'hCAFE, 32'hBEEF_00A5, "ram_pt");

      // Accumulated events from the table, then cleared by the read.
      drive(RD, 9'h181, 16'h0);
      tick(1'b0, 1'b1, 16'h7777, 32'hBEEF_00A5, "evt1_a");
      drive(RD, 9'h180, 16'h0);
      tick(1'b0, 1'b1, 16'h0055, 32'hBEEF_00A5, "evt0_a");
      drive(RD, 9'h181, 16'h0);
      tick(1'b0, 1'b1, 16'h0000, 32'hBEEF_00A5, "evt1_clr");

      // Leave an event pending, then reset with a read in flight.
      in_port = 32'h7776_0055;
      drive(NONE, 9'h0, 16'h0);
      tick(1'b0, 1'b0, 16'h0, 32'hBEEF_00A5, "evt1_set");
      reset = 1'b1;
      drive(RD, 9'h100, 16'h0);
      tick(1'b0, 1'b0, 16'h0, 32'h0, "rst_mid");
      reset = 1'b0;
      drive(RD, 9'h181, 16'h0);
      tick(1'b0, 1'b1, 16'h0000, 32'h0, "evt1_rst");
      drive(RD, 9'h180, 16'h0);
      tick(1'b0, 1'b1, 16'h0000, 32'h0, "evt0_rst");
      drive(RD, 9'h1C0, 16'h0);
      tick(1'b0, 1'b1, 16'h0000, 32'h0, "unmap");

      // Single bit change, read, read again.
      in_port = 32'h7776_005D;
      drive(NONE, 9'h0, 16'h0);
      tick(1'b0, 1'b0, 16'h0, 32'h0, "b3_set");
      drive(RD, 9'h180, 16'h0);
      tick(1'b0, 1'b1, 16'h0008, 32'h0, "b3_rd");
      drive(RD, 9'h180, 16'h0);
      tick(1'b0, 1'b1, 16'h0000, 32'h0, "b3_clr");

      // Change arriving in the same cycle as the clearing read wins.
      in_port = 32'h7776_005F;
      drive(NONE, 9'h0, 16'h0);
      tick(1'b0, 1'b0, 16'h0, 32'h0, "b1_set");
      in_port = 32'h7776_005E;
      drive(RD, 9'h180, 16'h0);
      tick(1'b0, 1'b1, 16'h0002, 32'h0, "race_rd");
      drive(RD, 9'h180, 16'h0);
      tick(1'b0, 1'b1, 16'h0001, 32'h0, "race_new");
      drive(RD, 9'h180, 16'h0);
      tick(1'b0, 1'b1, 16'h0000, 32'h0, "race_clr");
      drive(NONE, 9'h0, 16'h0);
      tick(1'b0, 1'b0, 16'h0, 32'h0, "idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
